prng_sample_capture: RTL and testbench
======================================

// Module: prng_sample_capture
// PURPOSE
//  Consumer end of the divided-clock PRNG path. Captures one PRNG sample on each rising
//  edge of the divider carry-out strobe, buffers samples in a small FIFO, and hands them
//  to the FIR input stage over a valid/ready handshake. Reports occupancy and overruns.
// PARAMETERS
//  DATA_W   16  sample width (PRNG output / FIR input word)
//  DEPTH     4  FIFO entries; power of two, >= 2
//  DROP_W    8  width of saturating dropped-sample counter
// PORTS
//  clk          in   1             system clock; all logic on posedge
//  rst          in   1             synchronous, active-low reset
//  tick         in   1             divider carry-out; level, may stay high if divider stalls
//  sample_in    in   DATA_W        PRNG output word, valid in the cycle tick rises
//  flush        in   1             synchronous clear of FIFO and status
//  out_valid    out  1             head sample available
//  out_ready    in   1             FIR stage accepts head sample
//  out_data     out  DATA_W        head sample; 0 when out_valid=0
//  level        out  $clog2(DEPTH)+1   entries currently stored, 0..DEPTH
//  overflow     out  1             sticky: a capture was dropped since reset/flush
//  drop_count   out  DROP_W        dropped captures, saturates at 2**DROP_W-1
// BEHAVIOUR
//  - Reset (rst==0 at posedge): FIFO empty, level=0, out_valid=0, out_data=0,
//    overflow=0, drop_count=0, tick_d=0. A tick already high after reset counts as a rise.
//  - Capture event cap = tick & ~tick_d; tick_d <= tick every non-reset cycle (incl. flush).
//    Tick held high N cycles -> exactly one capture.
//  - Push: cap && (!full || pop). sample_in written at end of cycle n; out_valid=1 in n+1
//    if FIFO was empty. No combinational bypass: capture-to-valid latency = 1 cycle.
//  - Pop: out_valid && out_ready; head advances at end of that cycle.
//  - Full + cap + pop same cycle: both happen, level unchanged, no drop.
//  - Full + cap, no pop: sample discarded, overflow<=1, drop_count+1 (saturating).
//  - Empty + out_ready: no effect. Empty + cap + out_ready: push only.
//  - level: +1 on push-only, -1 on pop-only, unchanged on both/neither.
//  - flush: highest priority below reset; empties FIFO, clears overflow and drop_count;
//    any push/pop in that cycle is ignored. out_valid=0 next cycle.
//  - Pointers: PTR_W=$clog2(DEPTH) bits, wrap modulo DEPTH; full/empty from level.
//  - out_data is registered head or muxed head gated with out_valid; never X after reset.
// STRUCTURE
//  - Shared package fir_pkg: DATA_W default (16), DROP_W default (8), sample word typedef.
//  - One sub-module: sync_fifo (DATA_W, DEPTH; push/pop/flush, level, full/empty, FWFT head).
//  - Top holds edge detect, push/drop decision, overflow/drop_count logic.
// TESTING
//  1 Reset: rst=0 3 cycles with tick=1 -> all outputs 0; release -> one capture, level=1.
//  2 Single capture: tick 0->1 with sample_in=16'hA5A5, held high 5 cycles -> exactly one
//    entry; out_valid next cycle, out_data=16'hA5A5; pop -> level=0, out_data=0.
//  3 Overflow: out_ready=0, 6 tick pulses (DEPTH=4) -> level=4, overflow=1, drop_count=2;
//    FIFO holds first 4 samples in order.
//  4 Full with simultaneous pop: level=4, tick rise + out_ready=1 same cycle -> level stays 4,
//    drop_count unchanged, new sample at tail.
//  5 Saturation/flush: DROP_W=2, 8 drops -> drop_count=3; flush=1 -> level=0, overflow=0,
//    drop_count=0, out_valid=0 next cycle; tick rise during flush cycle not stored.
//  6 Streaming: tick every 4 cycles, out_ready=1 always -> out_data sequence matches
//    sample_in order, level never exceeds 1, overflow stays 0.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared sizing and sample word type for the PRNG-to-FIR path
// Purpose: default widths used by the capture front end and the FIR input stage.
package fir_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DROP_W_DEF = 8;

    typedef logic [DATA_W_DEF-1:0] sample_t;

endpackage

// File: rtl/prng_sample_capture_sync_fifo.sv
// rtl/prng_sample_capture_sync_fifo.sv - first-word-fall-through synchronous FIFO
// Purpose: small sample buffer between the capture strobe and the FIR handshake.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   push, pop       write tail / advance head (ignored when flush is high)
//   flush           synchronous clear of pointers and level
//   wr_data         word written at tail on push
//   rd_data         head word, 0 while empty
//   level           stored entries, 0..DEPTH
//   full, empty     derived from level
module sync_fifo
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    // Head is gated so nothing stale ever leaves an empty FIFO.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // A push into a full FIFO is only legal when the head leaves in the same
        // cycle; the tail slot then coincides with the slot being freed.
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/prng_sample_capture.sv
// rtl/prng_sample_capture.sv - captures PRNG samples on divider strobe rises into a FIFO
// Purpose: edge-detect the divider carry-out, buffer one sample per rise, present
// them to the FIR stage over valid/ready, and report occupancy and overruns.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   tick            divider carry-out level; a rise captures sample_in
//   sample_in       PRNG word
//   flush           synchronous clear of FIFO, overflow and drop_count
//   out_valid/out_ready/out_data   head sample handshake (data 0 when not valid)
//   level           stored entries
//   overflow        sticky dropped-capture flag
//   drop_count      saturating dropped-capture count
module prng_sample_capture
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [DATA_W-1:0]        sample_in,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count
);

    logic              tick_d_q, tick_d_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;

    logic              cap;
    logic              pop;
    logic              push;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;

    always_comb begin
        // tick_d resets to 0, so a tick already high when reset lifts is a rise.
        cap          = tick & ~tick_d_q;
        pop          = out_valid & out_ready;
        push         = cap & (~fifo_full | pop);
        drop         = cap & fifo_full & ~pop;
        tick_d_d     = tick;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (flush) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_d_q     <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            tick_d_q     <= tick_d_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (sample_in),
        .rd_data (out_data),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid  = ~fifo_empty;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_prng_sample_capture.sv
// tb/tb_prng_sample_capture.sv - self-checking bench for prng_sample_capture
module tb_prng_sample_capture;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;
    localparam int MAX_DROPS = (1 << DROP_W) - 1;

    logic              clk;
    logic              rst;
    logic              tick;
    logic [DATA_W-1:0] sample_in;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        level;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] mq[$];
    bit                m_ovf;
    int                m_drops;
    bit                m_prev_tick;

    prng_sample_capture #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .sample_in  (sample_in),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: a queue of stored samples, updated once per clock edge.
    task automatic model_edge();
        bit cap;
        bit pop;
        if (!rst) begin
            mq.delete();
            m_ovf       = 0;
            m_drops     = 0;
            m_prev_tick = 0;
        end else begin
            cap         = tick && !m_prev_tick;
            m_prev_tick = tick;
            if (flush) begin
                mq.delete();
                m_ovf   = 0;
                m_drops = 0;
            end else begin
                pop = (mq.size() > 0) && out_ready;
                if (pop) void'(mq.pop_front());
                if (cap) begin
                    if (mq.size() < DEPTH) mq.push_back(sample_in);
                    else begin
                        m_ovf = 1;
                        if (m_drops < MAX_DROPS) m_drops++;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("out_data", 32'(out_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        check("level", 32'(level), 32'(mq.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_count", 32'(drop_count), 32'(m_drops));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst       = 1'b0;
        tick      = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        sample_in = 16'h0;
        mq.delete();
        m_ovf = 0; m_drops = 0; m_prev_tick = 0;

        // Reset held with tick high
        for (int i = 0; i < 3; i++) begin
            sample_in = 16'($urandom);
            step();
        end
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_level", 32'(level), 32'd0);

        rst = 1'b1;
        sample_in = 16'h1234;
        step();
        check("post_reset_level", 32'(level), 32'd1);
        check("post_reset_data", 32'(out_data), 32'h1234);
        tick = 1'b0; out_ready = 1'b1;
        step();

        // Single capture with tick held high
        out_ready = 1'b0;
        tick = 1'b1; sample_in = 16'hA5A5;
        step();
        check("single_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            sample_in = 16'($urandom);
            step();
        end
        check("single_level", 32'(level), 32'd1);
        check("single_data", 32'(out_data), 32'hA5A5);
        out_ready = 1'b1;
        step();
        check("single_pop_level", 32'(level), 32'd0);
        check("single_pop_data", 32'(out_data), 32'd0);

        // Overflow: six pulses into four entries
        tick = 1'b0; out_ready = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            tick = 1'b1; sample_in = 16'($urandom);
            step();
            tick = 1'b0;
            step();
        end
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_count), 32'd2);

        // Full with simultaneous pop and capture
        tick = 1'b1; out_ready = 1'b1; sample_in = 16'hBEEF;
        step();
        check("full_pop_level", 32'(level), 32'd4);
        check("full_pop_drops", 32'(drop_count), 32'd2);
        tick = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("drained_level", 32'(level), 32'd0);

        // Drop-count saturation then flush
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + MAX_DROPS + 5; i++) begin
            tick = 1'b1; sample_in = 16'($urandom);
            step();
            tick = 1'b0;
            step();
        end
        check("sat_drops", 32'(drop_count), 32'(MAX_DROPS));
        flush = 1'b1; tick = 1'b1; sample_in = 16'h7777;
        step();
        flush = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_ovf", 32'(overflow), 32'd0);
        check("flush_drops", 32'(drop_count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        step();
        check("flush_tick_ignored", 32'(level), 32'd0);

        // Streaming with a capture every fourth cycle
        tick = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick = ((i % 4) == 0);
            sample_in = 16'($urandom);
            step();
            check("stream_level_le1", 32'(level <= 3'd1), 32'd1);
        end
        check("stream_ovf", 32'(overflow), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            tick      = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 40) == 0);
            sample_in = 16'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
